// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg: shared state encodings, port indices and counter width for the EEPROM scheduler.
package i2c_ctrl_pkg;
    localparam int CNT_W  = 24;
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RESP, ST_TWR} state_t;
endpackage

// File: rtl/i2c_rr_arb.sv
// i2c_rr_arb: 2-way round-robin grant; last = 1 means port B was served last, so A wins a tie.
module i2c_rr_arb
    import i2c_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    output logic [1:0] gnt
);
    assign gnt[PORT_A] = en & req[PORT_A] & (~req[PORT_B] | last);
    assign gnt[PORT_B] = en & req[PORT_B] & (~req[PORT_A] | ~last);
endmodule

// File: rtl/i2c_eeprom_arb.sv
// i2c_eeprom_arb: schedules two request ports onto one i2c_drv engine, with a
// post-write tWR guard and a per-transaction watchdog.
module i2c_eeprom_arb
    import i2c_ctrl_pkg::*;
#(
    parameter logic ADDR_HL     = 1'b1,
    parameter int   TWR_CYCLES  = 250_000,
    parameter int   TIMEOUT_CYC = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [7:0]  b_rdata,
    output logic        busy,
    output logic        drv_exec,
    output logic        drv_we,
    output logic        drv_addr_hl,
    output logic [15:0] drv_word_addr,
    output logic [7:0]  drv_wdata,
    input  logic [7:0]  drv_rdata,
    input  logic        drv_done
);
    localparam logic [CNT_W-1:0] TWR_LAST = CNT_W'(TWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic               last_q, last_d, win_q, win_d, we_q, we_d, err_q, err_d, done_d_q;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         gnt;
    logic               done_rise;

    i2c_rr_arb u_arb (
        .req  ({b_req, a_req}),
        .en   (state_q == ST_IDLE),
        .last (last_q),
        .gnt  (gnt)
    );

    assign done_rise = drv_done & ~done_d_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        cnt_d     = '0;
        case (state_q)
            ST_IDLE: if (|gnt) begin
                win_d   = gnt[PORT_B];
                last_d  = gnt[PORT_B];
                we_d    = gnt[PORT_B] ? b_we : a_we;
                addr_d  = gnt[PORT_B] ? b_addr : a_addr;
                wdata_d = gnt[PORT_B] ? b_wdata : a_wdata;
                err_d   = 1'b0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // A done edge on the timeout cycle still counts as success.
                if (done_rise) begin
                    state_d = ST_RESP;
                    if (!we_q && win_q) b_rdata_d = drv_rdata;
                    if (!we_q && !win_q) a_rdata_d = drv_rdata;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = (we_q | err_q) ? ST_TWR : ST_IDLE;
            ST_TWR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == TWR_LAST) ? ST_IDLE : ST_TWR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'(PORT_B);
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            done_d_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            we_q      <= we_d;
            err_q     <= err_d;
            done_d_q  <= drv_done;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy          = state_q != ST_IDLE;
    assign drv_exec      = state_q == ST_ISSUE;
    assign a_ack         = (state_q == ST_RESP) & ~win_q;
    assign b_ack         = (state_q == ST_RESP) & win_q;
    assign a_err         = a_ack & err_q;
    assign b_err         = b_ack & err_q;
    assign a_rdata       = a_rdata_q;
    assign b_rdata       = b_rdata_q;
    assign drv_we        = we_q;
    assign drv_addr_hl   = ADDR_HL;
    assign drv_word_addr = addr_q;
    assign drv_wdata     = wdata_q;
endmodule

// File: tb/tb_i2c_eeprom_arb.sv
// tb_i2c_eeprom_arb: table vectors, hand sequences and random traffic checked by a
// transaction-level monitor against a reference memory and the scheduling rules.
module tb_i2c_eeprom_arb;
    localparam int TWR = 20;
    localparam int TMO = 500;

    logic clk = 0, rst = 1;
    logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [15:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic a_ack, a_err, b_ack, b_err, busy, drv_exec, drv_we, drv_addr_hl;
    logic [7:0] a_rdata, b_rdata, drv_wdata;
    logic [7:0] drv_rdata = 0;
    logic drv_done = 0;
    logic [15:0] drv_word_addr;

    i2c_eeprom_arb #(.ADDR_HL(1'b1), .TWR_CYCLES(TWR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .busy(busy), .drv_exec(drv_exec), .drv_we(drv_we), .drv_addr_hl(drv_addr_hl),
        .drv_word_addr(drv_word_addr), .drv_wdata(drv_wdata),
        .drv_rdata(drv_rdata), .drv_done(drv_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // EEPROM + engine model: done high for 4 clk starting 30 clk after exec.
    bit hang = 0;
    int dcnt = -1;
    logic m_we;
    logic [15:0] m_addr;
    logic [7:0] m_wd;
    logic [7:0] eep [logic [15:0]];
    logic [7:0] refm [logic [15:0]];
    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction
    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    always @(negedge clk) begin
        if (rst) dcnt = -1;
        else if (drv_exec) begin
            dcnt = 0; m_we = drv_we; m_addr = drv_word_addr; m_wd = drv_wdata;
        end else if (dcnt >= 0) dcnt++;
        if (dcnt >= 34) dcnt = -1;
        if (!hang && dcnt == 30) begin
            if (m_we) eep[m_addr] = m_wd;
            else drv_rdata = eep.exists(m_addr) ? eep[m_addr] : dflt(m_addr);
        end
        drv_done = !hang && dcnt >= 30 && dcnt < 34;
    end

    // Transaction monitor
    int execs = 0, last_exec = 0, last_ack = 0, exp_next = -1;
    bit guard = 0, have_ack = 0, a_prev = 0, b_prev = 0;
    int order[$];

    task automatic check_ack(input int p);
        logic we = p ? b_we : a_we;
        logic [15:0] addr = p ? b_addr : a_addr;
        logic [7:0] wd = p ? b_wdata : a_wdata;
        logic e = p ? b_err : a_err;
        logic [7:0] rd = p ? b_rdata : a_rdata;
        order.push_back(p);
        chk("ack_one_cycle", p ? b_prev : a_prev, 0);
        chk("ack_exclusive", a_ack & b_ack, 0);
        if (exp_next >= 0) chk("rr_order", p, exp_next);
        exp_next = (p ? a_req : b_req) ? 1 - p : -1;
        chk("ack_err", e, hang);
        chk("ack_latency", cyc - last_exec, hang ? TMO + 1 : 31);
        chk("drv_word_addr", drv_word_addr, addr);
        chk("drv_we", drv_we, we);
        if (we) chk("drv_wdata", drv_wdata, wd);
        if (!hang) begin
            if (we) refm[addr] = wd;
            else chk("rdata", rd, ref_rd(addr));
        end
        guard = we | hang; have_ack = 1; last_ack = cyc;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_next = -1; have_ack = 0; a_prev = 0; b_prev = 0;
        end else begin
            if (drv_exec) begin
                execs++; last_exec = cyc;
                chk("busy_at_exec", busy, 1);
                if (have_ack && guard) chk("twr_gap", (cyc - last_ack) >= TWR + 2, 1);
            end
            if (a_ack) check_ack(0);
            if (b_ack) check_ack(1);
            a_prev = a_ack; b_prev = b_ack;
        end
    end

    task automatic xact(input int p, input logic we, input logic [15:0] addr, input logic [7:0] wd);
        bit got = 0;
        @(posedge clk); #1;
        if (p == 0) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        else begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            got = p ? b_ack : a_ack;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL xact_timeout port %0d: no ack, required ack within 2000 cycles", p);
        end
        @(posedge clk); #1;
        if (p == 0) a_req = 0; else b_req = 0;
    endtask

    task automatic rst_outs(input string tag);
        chk({tag, "_outputs"}, {a_ack, a_err, b_ack, b_err, busy, drv_exec, drv_we, drv_word_addr, drv_wdata}, 0);
        chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
        chk({tag, "_addr_hl"}, drv_addr_hl, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        @(negedge clk); @(negedge clk);
        rst_outs("reset");
        @(posedge clk); #1 rst = 0;
    endtask

    typedef struct {
        int p; logic we; logic [15:0] addr; logic [7:0] wd; logic [7:0] exp;
    } vec_t;
    vec_t vt[6];

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not complete, required finish before 50000 cycles");
        $fatal(1);
    end

    initial begin
        int n0, ob, start;
        logic [7:0] v;
        bit got;
        eep[16'h0012] = 8'h5A; refm[16'h0012] = 8'h5A;
        vt[0] = '{0, 1'b0, 16'h0012, 8'h00, 8'h5A};
        vt[1] = '{0, 1'b1, 16'h0101, 8'hA5, 8'h00};
        vt[2] = '{1, 1'b0, 16'h0101, 8'h00, 8'hA5};
        vt[3] = '{1, 1'b1, 16'h0200, 8'h77, 8'h00};
        vt[4] = '{0, 1'b0, 16'h0200, 8'h00, 8'h77};
        vt[5] = '{1, 1'b0, 16'h0012, 8'h00, 8'h5A};
        repeat (2) @(negedge clk);
        do_reset();

        foreach (vt[i]) begin
            n0 = execs; ob = order.size();
            xact(vt[i].p, vt[i].we, vt[i].addr, vt[i].wd);
            chk("vec_execs", execs - n0, 1);
            chk("vec_ack_count", order.size() - ob, 1);
            if (order.size() > ob) chk("vec_ack_port", order[ob], vt[i].p);
            if (!vt[i].we) chk("vec_rdata", vt[i].p ? b_rdata : a_rdata, vt[i].exp);
        end

        // Simultaneous requests after reset: A first, then B.
        do_reset();
        order.delete(); n0 = execs;
        fork
            xact(0, 1'b0, 16'h0040, 8'h00);
            xact(1, 1'b0, 16'h0041, 8'h00);
        join
        chk("tie_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("tie_first", order[0], 0);
            chk("tie_second", order[1], 1);
        end
        chk("tie_execs", execs - n0, 2);

        // A write with B read pending: B waits out the write guard.
        order.delete();
        fork
            xact(0, 1'b1, 16'h0100, 8'hC3);
            begin repeat (3) @(posedge clk); xact(1, 1'b0, 16'h0100, 8'h00); end
        join
        chk("wr_then_rd_count", order.size(), 2);
        if (order.size() == 2) chk("wr_then_rd_first", order[0], 0);
        chk("wr_then_rd_data", b_rdata, 8'hC3);

        // Engine never completes: timeout error then guard.
        hang = 1; v = a_rdata;
        xact(0, 1'b0, 16'h0012, 8'h00);
        chk("err_rdata_held", a_rdata, v);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = !busy;
        end
        chk("err_guard_len", cyc - last_ack, TWR + 1);
        hang = 0;

        // A held continuously, B once: no starvation.
        order.delete();
        fork
            for (int k = 0; k < 3; k++) xact(0, 1'b0, 16'h0050 + 16'(k), 8'h00);
            begin repeat (5) @(posedge clk); xact(1, 1'b0, 16'h0060, 8'h00); end
        join
        chk("rr_held_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("rr_held_0", order[0], 0);
            chk("rr_held_1", order[1], 1);
            chk("rr_held_2", order[2], 0);
        end

        // Reset during BUSY aborts with no ack.
        order.delete();
        @(posedge clk); #1 a_req = 1; a_we = 0; a_addr = 16'h0012;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = drv_exec;
        end
        chk("abort_exec_seen", got, 1);
        repeat (10) @(negedge clk);
        #1 rst = 1; a_req = 0;
        #1 rst_outs("abort_async");
        @(negedge clk);
        rst_outs("abort");
        @(posedge clk); #1 rst = 0;
        repeat (40) @(negedge clk);
        chk("abort_no_ack", order.size(), 0);
        xact(0, 1'b0, 16'h0012, 8'h00);
        chk("abort_fresh_rdata", a_rdata, 8'h5A);
        chk("abort_fresh_count", order.size(), 1);

        // Random two-port traffic over a small address window.
        order.delete();
        fork
            for (int k = 0; k < 12; k++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                xact(0, 1'($urandom_range(0, 1)), 16'h0300 + 16'($urandom_range(0, 3)), 8'($urandom));
            end
            for (int k = 0; k < 12; k++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                xact(1, 1'($urandom_range(0, 1)), 16'h0300 + 16'($urandom_range(0, 3)), 8'($urandom));
            end
        join
        chk("rand_ack_count", order.size(), 24);

        start = cyc;
        repeat (30) @(negedge clk);
        chk("idle_not_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
